// File: rtl/eth_mii_tx.sv
`default_nettype none
// ============================================================================
// Module  : eth_mii_tx
// Purpose : MII frame transmitter (preamble, SFD, payload, pad, FCS, IPG).
// Rev     : 1.0  initial release
// ============================================================================
module eth_mii_tx #(
    parameter int MTU     = 1536,
    parameter int ADDR_W  = 11,
    parameter int IPG_NIB = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       len,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [7:0]        buf_rdata,
    output logic [3:0]        txd,
    output logic              tx_en
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_SFD  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_PAD  = 3'd4;
    localparam logic [2:0] S_FCS  = 3'd5;
    localparam logic [2:0] S_IPG  = 3'd6;

    // Byte counter is one bit wider than the address so len == MTU is representable.
    localparam int LW = ADDR_W + 1;
    localparam int CW = ($clog2(IPG_NIB) > 4) ? $clog2(IPG_NIB) : 4;

    localparam logic [LW-1:0] MIN_BYTES = LW'(60);
    localparam logic [15:0]   MTU_LEN   = 16'(MTU);
    localparam logic [CW-1:0] PRE_LAST  = CW'(14);
    localparam logic [CW-1:0] FCS_LAST  = CW'(7);
    localparam logic [CW-1:0] IPG_LAST  = CW'(IPG_NIB - 1);
    localparam logic [31:0]   CRC_POLY  = 32'hEDB88320;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              nib_q, nib_d;
    logic [LW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [LW-1:0]     len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        hi_q, hi_d;
    logic [31:0]       crc_q, crc_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [LW-1:0]     byte_next;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            nib_q      <= 1'b0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            hi_q       <= '0;
            crc_q      <= 32'hFFFFFFFF;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nib_q      <= nib_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            hi_q       <= hi_d;
            crc_q      <= crc_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign byte_next = byte_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nib_d      = nib_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        addr_d     = addr_q;
        hi_d       = hi_q;
        crc_d      = crc_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len == 16'd0 || len > MTU_LEN) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_PRE;
                        len_d   = len[LW-1:0];
                        cnt_d   = '0;
                        addr_d  = '0;
                    end
                end
            end
            S_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = S_SFD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SFD: begin
                state_d    = S_DATA;
                crc_d      = 32'hFFFFFFFF;
                byte_cnt_d = '0;
                nib_d      = 1'b0;
            end
            S_DATA: begin
                // Low-nibble cycle: the RAM word is live; fold it into the CRC, keep
                // its high nibble and request the next byte while still inside the frame.
                if (!nib_q) begin
                    nib_d = 1'b1;
                    hi_d  = buf_rdata[7:4];
                    crc_d = crc_byte(crc_q, buf_rdata);
                    if (byte_next < len_q) begin
                        addr_d = byte_next[ADDR_W-1:0];
                    end
                end else begin
                    nib_d      = 1'b0;
                    byte_cnt_d = byte_next;
                    if (byte_next == len_q) begin
                        state_d = (len_q < MIN_BYTES) ? S_PAD : S_FCS;
                        cnt_d   = '0;
                    end
                end
            end
            S_PAD: begin
                if (!nib_q) begin
                    nib_d = 1'b1;
                end else begin
                    nib_d      = 1'b0;
                    crc_d      = crc_byte(crc_q, 8'h00);
                    byte_cnt_d = byte_next;
                    if (byte_next == MIN_BYTES) begin
                        state_d = S_FCS;
                        cnt_d   = '0;
                    end
                end
            end
            S_FCS: begin
                crc_d = {4'hF, crc_q[31:4]};
                if (cnt_q == FCS_LAST) begin
                    state_d = S_IPG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IPG: begin
                if (cnt_q == IPG_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != S_IDLE);
        tx_en = 1'b0;
        txd   = 4'h0;
        case (state_q)
            S_PRE: begin
                tx_en = 1'b1;
                txd   = 4'h5;
            end
            S_SFD: begin
                tx_en = 1'b1;
                txd   = 4'hD;
            end
            S_DATA: begin
                tx_en = 1'b1;
                txd   = nib_q ? hi_q : buf_rdata[3:0];
            end
            S_PAD: begin
                tx_en = 1'b1;
                txd   = 4'h0;
            end
            S_FCS: begin
                tx_en = 1'b1;
                txd   = ~crc_q[3:0];
            end
            default: begin
                tx_en = 1'b0;
                txd   = 4'h0;
            end
        endcase
    end

    assign done     = done_q;
    assign err_len  = err_q;
    assign buf_addr = addr_q;

endmodule
`default_nettype wire
